// File: rtl/bank_htu_pkg.sv
// Shared definitions for the bank HTU set-associative entry: sector state
// encoding and the bit positions of the one-hot request opcode.
package bank_htu_pkg;

    typedef logic [1:0] sec_state_t;

    localparam sec_state_t ST_INV   = 2'd0;
    localparam sec_state_t ST_CLEAN = 2'd1;
    localparam sec_state_t ST_DIRTY = 2'd2;
    localparam sec_state_t ST_BUSY  = 2'd3;

    // Bit positions inside the packed one-hot opcode {inv, flush, write, read}
    localparam int unsigned OP_READ       = 32'd0;
    localparam int unsigned OP_WRITE      = 32'd1;
    localparam int unsigned OP_FLUSH      = 32'd2;
    localparam int unsigned OP_INVALIDATE = 32'd3;
    localparam int unsigned OP_NUM        = 32'd4;

endpackage

// File: rtl/bank_htu_plru_tree_n.sv
// Tree pseudo-LRU for one set. Nodes are heap-ordered: node n has its lower
// child at 2n+1 and upper child at 2n+2. A node bit of 0 means the victim
// lies in the lower half of that node's range.
module bank_htu_plru_tree_n #(
    parameter  int WAYS  = 8,
    localparam int WAY_W = (WAYS > 2) ? $clog2(WAYS) : 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             update_i,
    input  logic [WAY_W-1:0] access_way_i,
    output logic [WAY_W-1:0] victim_way_o
);

    localparam int LVLS  = $clog2(WAYS);
    localparam int NODES = WAYS - 1;

    logic [NODES-1:0] tree_r;
    logic [NODES-1:0] tree_next_s;

    // Walk from the root following the node bits to find the victim way
    always_comb begin
        logic [WAY_W-1:0] node;
        node         = '0;
        victim_way_o = '0;
        for (int l = 0; l < LVLS; l++) begin
            victim_way_o[LVLS-1-l] = tree_r[node];
            node = (node << 1) + WAY_W'(1'b1) + WAY_W'(tree_r[node]);
        end
    end

    // Point every node on the accessed way's path away from that way
    always_comb begin
        logic [WAY_W-1:0] node;
        node        = '0;
        tree_next_s = tree_r;
        for (int l = 0; l < LVLS; l++) begin
            tree_next_s[node] = ~access_way_i[LVLS-1-l];
            node = (node << 1) + WAY_W'(1'b1) + WAY_W'(access_way_i[LVLS-1-l]);
        end
    end

    // Tree register, only advanced on accepted hits and allocations
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tree_r <= '0;
        end else if (update_i) begin
            tree_r <= tree_next_s;
        end else begin
            tree_r <= tree_r;
        end
    end

endmodule

// File: rtl/bank_htu_set_assoc.sv
// One cache set of WAYS ways with SECTORS independently tracked sectors per
// line. Resolves one request per cycle (hit/miss, victim, stall) and updates
// sector state, tags and the PLRU tree at the following clock edge.
module bank_htu_set_assoc
    import bank_htu_pkg::*;
#(
    parameter  int WAYS    = 8,
    parameter  int SECTORS = 2,
    parameter  int TAG_W   = 22,
    localparam int WAY_W   = (WAYS > 2) ? $clog2(WAYS) : 1,
    localparam int SEC_W   = (SECTORS > 2) ? $clog2(SECTORS) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req_valid_i,
    input  logic                 op_is_read_i,
    input  logic                 op_is_write_i,
    input  logic                 op_is_flush_i,
    input  logic                 op_is_invalidate_i,
    input  logic [TAG_W-1:0]     access_tag_i,
    input  logic [SEC_W-1:0]     access_sector_i,
    input  logic                 refill_done_i,
    input  logic [WAY_W-1:0]     refill_way_i,
    input  logic [SEC_W-1:0]     refill_sector_i,
    output logic                 resp_hit_o,
    output logic                 resp_stall_o,
    output logic [WAY_W-1:0]     resp_way_o,
    output logic [2*SECTORS-1:0] resp_sector_state_o,
    output logic                 refill_req_o,
    output logic                 wb_valid_o,
    output logic [TAG_W-1:0]     wb_tag_o,
    output logic [SECTORS-1:0]   wb_mask_o
);

    localparam int LW = 2 * SECTORS;

    logic [TAG_W-1:0]              tag_r       [WAYS];
    logic [LW-1:0]                 line_r      [WAYS];
    logic [TAG_W-1:0]              tag_next_s  [WAYS];
    logic [LW-1:0]                 line_next_s [WAYS];

    logic [WAYS-1:0]               way_valid_s;
    logic [WAYS-1:0]               way_busy_s;
    logic [WAYS-1:0]               way_match_s;
    logic [WAYS-1:0][SECTORS-1:0]  dirty_mask_s;

    logic [OP_NUM-1:0]   op_s;
    logic                act_s;
    logic                hit_s;
    logic                has_inv_s;
    logic [WAY_W-1:0]    hit_way_s;
    logic [WAY_W-1:0]    inv_way_s;
    logic [WAY_W-1:0]    plru_victim_s;
    logic [WAY_W-1:0]    victim_s;
    logic [WAY_W-1:0]    sel_way_s;
    logic [LW-1:0]       sel_line_s;
    logic [SECTORS-1:0]  sec_sel_s;
    logic [SECTORS-1:0]  refill_sel_s;
    sec_state_t          cur_sec_s;

    logic                stall_s;
    logic                refill_req_s;
    logic                wb_valid_s;
    logic [TAG_W-1:0]    wb_tag_s;
    logic [SECTORS-1:0]  wb_mask_s;
    logic                upd_line_s;
    logic                upd_tag_s;
    logic                plru_upd_s;
    logic [WAY_W-1:0]    resp_way_s;
    logic [LW-1:0]       new_line_s;

    // Overwrite the selected sectors of a line with one state value
    function automatic logic [LW-1:0] set_sector(input logic [LW-1:0] line,
                                                 input logic [SECTORS-1:0] sel,
                                                 input sec_state_t val);
        logic [LW-1:0] res;
        res = line;
        for (int s = 0; s < SECTORS; s++) begin
            res[2*s +: 2] = sel[s] ? val : line[2*s +: 2];
        end
        return res;
    endfunction

    assign op_s  = {op_is_invalidate_i, op_is_flush_i, op_is_write_i, op_is_read_i};
    // Reset also silences the response so nothing is reported mid-reset
    assign act_s = req_valid_i & ~rst_i;

    // Per-way status decode: live, busy and dirty sectors plus tag match
    for (genvar w = 0; w < WAYS; w++) begin : g_way
        logic [SECTORS-1:0] sec_live_s;
        logic [SECTORS-1:0] sec_busy_s;
        logic [SECTORS-1:0] sec_dirty_s;
        for (genvar s = 0; s < SECTORS; s++) begin : g_sec
            assign sec_live_s[s]  = (line_r[w][2*s +: 2] != ST_INV);
            assign sec_busy_s[s]  = (line_r[w][2*s +: 2] == ST_BUSY);
            assign sec_dirty_s[s] = (line_r[w][2*s +: 2] == ST_DIRTY);
        end
        assign way_valid_s[w]  = |sec_live_s;
        assign way_busy_s[w]   = |sec_busy_s;
        assign dirty_mask_s[w] = sec_dirty_s;
        assign way_match_s[w]  = way_valid_s[w] && (tag_r[w] == access_tag_i);
    end

    // One-hot sector selects for the request and the refill port
    always_comb begin
        for (int s = 0; s < SECTORS; s++) begin
            sec_sel_s[s]    = (SECTORS == 1) || (SEC_W'(s) == access_sector_i);
            refill_sel_s[s] = (SECTORS == 1) || (SEC_W'(s) == refill_sector_i);
        end
    end

    // Lowest-index hit way and lowest-index fully invalid way
    always_comb begin
        hit_way_s = '0;
        inv_way_s = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            hit_way_s = way_match_s[w] ? WAY_W'(w) : hit_way_s;
            inv_way_s = way_valid_s[w] ? inv_way_s : WAY_W'(w);
        end
        hit_s     = |way_match_s;
        has_inv_s = ~&way_valid_s;
    end

    bank_htu_plru_tree_n #(.WAYS(WAYS)) u_plru (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .update_i     (plru_upd_s),
        .access_way_i (resp_way_s),
        .victim_way_o (plru_victim_s)
    );

    // Invalid ways are consumed before the PLRU victim is considered
    always_comb begin
        victim_s   = has_inv_s ? inv_way_s : plru_victim_s;
        sel_way_s  = hit_s ? hit_way_s : victim_s;
        sel_line_s = line_r[sel_way_s];
        cur_sec_s  = ST_INV;
        for (int s = 0; s < SECTORS; s++) begin
            cur_sec_s = sec_sel_s[s] ? sec_state_t'(sel_line_s[2*s +: 2]) : cur_sec_s;
        end
    end

    // Request decode: stall, writeback, refill request and the update to apply
    always_comb begin
        stall_s      = 1'b0;
        refill_req_s = 1'b0;
        wb_valid_s   = 1'b0;
        wb_tag_s     = '0;
        wb_mask_s    = '0;
        upd_line_s   = 1'b0;
        upd_tag_s    = 1'b0;
        plru_upd_s   = 1'b0;
        resp_way_s   = '0;
        new_line_s   = sel_line_s;
        if (act_s && (op_s[OP_READ] || op_s[OP_WRITE])) begin
            resp_way_s = sel_way_s;
            if (hit_s && (cur_sec_s == ST_BUSY)) begin
                stall_s = 1'b1;
            end else if (hit_s) begin
                plru_upd_s = 1'b1;
                if (op_s[OP_WRITE]) begin
                    upd_line_s = 1'b1;
                    new_line_s = set_sector(sel_line_s, sec_sel_s, ST_DIRTY);
                end else if (cur_sec_s == ST_INV) begin
                    upd_line_s   = 1'b1;
                    refill_req_s = 1'b1;
                    new_line_s   = set_sector(sel_line_s, sec_sel_s, ST_BUSY);
                end else begin
                    upd_line_s = 1'b0;
                end
            end else if (way_busy_s[victim_s]) begin
                stall_s = 1'b1;
            end else begin
                plru_upd_s = 1'b1;
                upd_line_s = 1'b1;
                upd_tag_s  = 1'b1;
                wb_valid_s = |dirty_mask_s[victim_s];
                wb_tag_s   = (|dirty_mask_s[victim_s]) ? tag_r[victim_s] : '0;
                wb_mask_s  = dirty_mask_s[victim_s];
                if (op_s[OP_WRITE]) begin
                    new_line_s = set_sector('0, sec_sel_s, ST_DIRTY);
                end else begin
                    refill_req_s = 1'b1;
                    new_line_s   = set_sector('0, sec_sel_s, ST_BUSY);
                end
            end
        end else if (act_s && hit_s && (op_s[OP_FLUSH] || op_s[OP_INVALIDATE])) begin
            resp_way_s = hit_way_s;
            if (way_busy_s[hit_way_s]) begin
                stall_s = 1'b1;
            end else if (op_s[OP_FLUSH]) begin
                upd_line_s = 1'b1;
                new_line_s = set_sector(sel_line_s, dirty_mask_s[hit_way_s], ST_CLEAN);
                wb_valid_s = |dirty_mask_s[hit_way_s];
                wb_tag_s   = (|dirty_mask_s[hit_way_s]) ? tag_r[hit_way_s] : '0;
                wb_mask_s  = dirty_mask_s[hit_way_s];
            end else begin
                upd_line_s = 1'b1;
                new_line_s = '0;
            end
        end else begin
            stall_s = 1'b0;
        end
    end

    // Next array state: request update first, then refill completion on top.
    // A refilled sector was BUSY, so an accepted request never changed it.
    always_comb begin
        for (int w = 0; w < WAYS; w++) begin
            line_next_s[w] = (upd_line_s && (resp_way_s == WAY_W'(w))) ? new_line_s : line_r[w];
            tag_next_s[w]  = (upd_tag_s && (resp_way_s == WAY_W'(w))) ? access_tag_i : tag_r[w];
            for (int s = 0; s < SECTORS; s++) begin
                line_next_s[w][2*s +: 2] =
                    (refill_done_i && (refill_way_i == WAY_W'(w)) && refill_sel_s[s] &&
                     (line_r[w][2*s +: 2] == ST_BUSY)) ? ST_CLEAN : line_next_s[w][2*s +: 2];
            end
        end
    end

    // Tag and sector state registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int w = 0; w < WAYS; w++) begin
                tag_r[w]  <= '0;
                line_r[w] <= '0;
            end
        end else begin
            for (int w = 0; w < WAYS; w++) begin
                tag_r[w]  <= tag_next_s[w];
                line_r[w] <= line_next_s[w];
            end
        end
    end

    assign resp_hit_o          = act_s & hit_s;
    assign resp_stall_o        = stall_s;
    assign resp_way_o          = resp_way_s;
    assign resp_sector_state_o = act_s ? line_r[resp_way_s] : '0;
    assign refill_req_o        = refill_req_s;
    assign wb_valid_o          = wb_valid_s;
    assign wb_tag_o            = wb_tag_s;
    assign wb_mask_o           = wb_mask_s;

endmodule

// File: doc/bank_htu_set_assoc.md
Name: bank_htu_set_assoc

Overview:
Parametrised successor of the bank HTU set entry. It holds one cache set of WAYS ways, each way with a tag and SECTORS independently tracked sectors. Each cycle it resolves one request against the set (hit/miss, way select, victim choice) and updates sector state and a tree-PLRU. It adds behaviour the previous set entry lacks:
- invalid-way-first allocation;
- a BUSY refill state with a refill-completion port;
- stall on conflicts;
- dirty-victim and flush writeback reporting.

Parameters:
WAYS, 8, associativity; power of 2, >=2
SECTORS, 2, sectors per line; power of 2, >=1
TAG_W, 22, tag width
(derived) WAY_W = max(1,clog2(WAYS)); SEC_W = max(1,clog2(SECTORS))

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-high
req_valid_i  in  1  request this cycle
op_is_read_i / op_is_write_i / op_is_flush_i / op_is_invalidate_i  in  1 each  one-hot op, qualified by req_valid_i
access_tag_i  in  TAG_W  request tag
access_sector_i  in  SEC_W  request sector (ignored for flush/invalidate)
refill_done_i  in  1  refill data written for (refill_way_i, refill_sector_i)
refill_way_i  in  WAY_W  refill way
refill_sector_i  in  SEC_W  refill sector
resp_hit_o  out  1  tag hit on a way with any sector != INV
resp_stall_o  out  1  request not accepted; requester replays it; no state change
resp_way_o  out  WAY_W  hit or allocated way
resp_sector_state_o  out  2*SECTORS  pre-update states of resp_way_o
refill_req_o  out  1  accessed sector entered BUSY; fetch needed
wb_valid_o  out  1  writeback required
wb_tag_o  out  TAG_W  tag of line to write back
wb_mask_o  out  SECTORS  dirty sectors to write back

Behaviour:
- Sector state encoding (2 bits): INV=0, CLEAN=1, DIRTY=2, BUSY=3.
- Reset (async, rst_i high):
  - all sectors INV, all tags 0, PLRU bits 0;
  - reset may assert at any time; any in-flight BUSY state is discarded.
- Outputs are combinational from registered state plus inputs (0-cycle latency). All outputs are 0 when req_valid_i=0. State updates at the next clk_i rising edge only when req_valid_i=1 and resp_stall_o=0.
- Read hit:
  - sector CLEAN/DIRTY: no state change.
  - sector INV: set it BUSY, refill_req_o=1.
  - sector BUSY: stall.
- Write hit: sector BUSY -> stall; otherwise sector -> DIRTY (full-sector write, no fetch).
- Read/write miss, victim selection:
  - victim = lowest-index way with all sectors INV; else the PLRU victim.
  - PLRU victim has any BUSY sector -> stall.
- Read/write miss, allocation:
  - if the victim has DIRTY sectors: wb_valid_o=1, wb_tag_o = old tag, wb_mask_o = DIRTY sectors;
  - victim tag <- access_tag_i, all sectors -> INV;
  - accessed sector -> BUSY (read, refill_req_o=1) or DIRTY (write);
  - resp_way_o = victim.
- Flush:
  - hit: DIRTY sectors -> CLEAN; wb_valid_o = |dirty, wb_tag_o = tag, wb_mask_o = dirty; stall if any sector BUSY.
  - miss: no-op.
- Invalidate:
  - hit: all sectors -> INV, dirty data discarded, no wb; stall if any sector BUSY.
  - miss: no-op.
- PLRU:
  - WAYS-1 tree bits; node bit 0 = victim in lower half.
  - Updated (path bits pointed away from resp_way_o) on accepted read/write hit or allocation only.
  - Flush, invalidate and stalls leave PLRU unchanged.
- Refill: refill_done_i with target sector BUSY -> CLEAN at the edge; a non-BUSY target is ignored.
- Simultaneous refill and request: the request is evaluated on pre-edge state.
  - If the request stalled on the refilled sector, its replay next cycle sees CLEAN.
  - If the request writes the same (way, sector) in the same cycle, it is necessarily stalled (sector was BUSY), so no conflict arises.
- Multiple tag matches cannot occur (allocation only on miss); behaviour under them is undefined.

Decomposition:
- Package bank_htu_pkg holds:
  - sector state localparams (INV/CLEAN/DIRTY/BUSY);
  - a 2-bit state typedef;
  - the op one-hot index constants.
- One sub-module, bank_htu_plru_tree_n (param WAYS):
  - inputs: clk_i, rst_i, update enable, access way;
  - output: victim way;
  - contains the tree register and the victim-walk logic.
- The tag/state array stays inline as generate loops.

Test Plan (WAYS=8, SECTORS=2, TAG_W=22):
1. Reset, read tag 0x100 sector 0 -> hit=0, way=0, refill_req=1, stall=0. Same read next cycle -> hit=1, stall=1. refill_done (way 0, sec 0), then reread -> hit=1, state sec0=CLEAN, no stall.
2. Writes to tags 0x100..0x107 sector 0 (each fills next invalid way 0..7, DIRTY). Then write tag 0x200 -> way=0 (PLRU victim after in-order fill), wb_valid=1, wb_tag=0x100, wb_mask=2'b01.
3. Flush hit on a way with both sectors DIRTY -> wb_mask=2'b11, states CLEAN/CLEAN. Next miss victim identical to pre-flush victim (PLRU unchanged).
4. All 8 ways allocated by reads without refill (all BUSY), then miss on new tag -> stall=1. Repeat the miss for 3 cycles -> tags, states and PLRU unchanged.
5. Invalidate hit on DIRTY line -> wb_valid=0, all INV. Next read miss allocates that way (invalid-first) even though PLRU points elsewhere.
6. Assert rst_i mid-cycle while ways are BUSY -> outputs 0 immediately. After release, read of a previously allocated tag -> hit=0, way=0.
